// File: rtl/dma_pkg.sv
// Shared constants for the DMA write path: bus width defaults and arbiter state encoding.
package dma_pkg;

    localparam int unsigned DmaDataW   = 256;
    localparam int unsigned DmaAddrW   = 32;
    localparam int unsigned DmaBcountW = 11;

    // Arbiter FSM encoding
    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StGrant0 = 2'd1;
    localparam logic [1:0] StGrant1 = 2'd2;

endpackage

// File: rtl/dma_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins; on a tie the channel that did not
// win last time wins.
module dma_rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       last_i,   // index of the most recent winner
    output logic [1:0] gnt_o     // one-hot winner, 2'b00 when nobody requests
);

    // Decode the request pair into a one-hot grant
    always_comb begin
        gnt_o = 2'b00;
        unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/dma_wr_arbiter.sv
// Two-channel burst write arbiter onto one AVMM burst write master. A channel owns the
// master from arbitration until its last beat is accepted; bursts are never preempted.
module dma_wr_arbiter
    import dma_pkg::*;
#(
    parameter int unsigned DATA_W   = DmaDataW,
    parameter int unsigned ADDR_W   = DmaAddrW,
    parameter int unsigned BCOUNT_W = DmaBcountW
) (
    input  logic                clk,
    input  logic                reset_n,

    input  logic                ch0_write_i,
    input  logic [ADDR_W-1:0]   ch0_addr_i,
    input  logic [BCOUNT_W-1:0] ch0_bcount_i,
    input  logic [DATA_W-1:0]   ch0_data_i,
    output logic                ch0_wait_req_o,
    output logic                ch0_burst_done_o,

    input  logic                ch1_write_i,
    input  logic [ADDR_W-1:0]   ch1_addr_i,
    input  logic [BCOUNT_W-1:0] ch1_bcount_i,
    input  logic [DATA_W-1:0]   ch1_data_i,
    output logic                ch1_wait_req_o,
    output logic                ch1_burst_done_o,

    output logic                wr_master_write_o,
    output logic [ADDR_W-1:0]   wr_master_addr_o,
    output logic [BCOUNT_W-1:0] wr_master_bcount_o,
    output logic [DATA_W-1:0]   wr_master_data_o,
    input  logic                wr_master_wait_req_i,

    output logic [1:0]          grant_o
);

    logic [1:0]          state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic [BCOUNT_W-1:0] beats_left_q, beats_left_d;
    logic                first_beat_q, first_beat_d;

    logic [1:0] pick;
    logic       accept;
    logic       last_beat;
    logic       burst_end;

    dma_rr_pick2 u_pick (
        .req_i  ({ch1_write_i, ch0_write_i}),
        .last_i (last_grant_q),
        .gnt_o  (pick)
    );

    // Route the owning channel straight to the master; everything idles low otherwise
    always_comb begin
        wr_master_write_o  = 1'b0;
        wr_master_addr_o   = '0;
        wr_master_bcount_o = '0;
        wr_master_data_o   = '0;
        ch0_wait_req_o     = 1'b1;
        ch1_wait_req_o     = 1'b1;
        grant_o            = 2'b00;
        unique case (state_q)
            StGrant0: begin
                wr_master_write_o  = ch0_write_i;
                wr_master_addr_o   = ch0_addr_i;
                wr_master_bcount_o = ch0_bcount_i;
                wr_master_data_o   = ch0_data_i;
                ch0_wait_req_o     = wr_master_wait_req_i;
                grant_o            = 2'b01;
            end
            StGrant1: begin
                wr_master_write_o  = ch1_write_i;
                wr_master_addr_o   = ch1_addr_i;
                wr_master_bcount_o = ch1_bcount_i;
                wr_master_data_o   = ch1_data_i;
                ch1_wait_req_o     = wr_master_wait_req_i;
                grant_o            = 2'b10;
            end
            default: ;
        endcase
    end

    // Beat acceptance and end-of-burst detection; a bcount of 0 counts as a single beat
    always_comb begin
        accept    = wr_master_write_o & ~wr_master_wait_req_i;
        last_beat = first_beat_q ? (wr_master_bcount_o <= BCOUNT_W'(1))
                                 : (beats_left_q == BCOUNT_W'(1));
        burst_end = accept & last_beat;
        ch0_burst_done_o = burst_end & (state_q == StGrant0);
        ch1_burst_done_o = burst_end & (state_q == StGrant1);
    end

    // Next-state: arbitrate from idle, then count beats until the burst ends
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        beats_left_d = beats_left_q;
        first_beat_d = first_beat_q;
        unique case (state_q)
            StIdle: begin
                first_beat_d = 1'b1;
                if (pick[0]) begin
                    state_d      = StGrant0;
                    last_grant_d = 1'b0;
                end else if (pick[1]) begin
                    state_d      = StGrant1;
                    last_grant_d = 1'b1;
                end
            end
            StGrant0, StGrant1: begin
                if (accept) begin
                    first_beat_d = 1'b0;
                    if (first_beat_q) begin
                        beats_left_d = (wr_master_bcount_o == '0) ? '0
                                     : wr_master_bcount_o - BCOUNT_W'(1);
                    end else begin
                        beats_left_d = beats_left_q - BCOUNT_W'(1);
                    end
                    if (last_beat) begin
                        state_d      = StIdle;
                        first_beat_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset favours channel 0 in the first contest
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            beats_left_q <= '0;
            first_beat_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            beats_left_q <= beats_left_d;
            first_beat_q <= first_beat_d;
        end
    end

endmodule

// File: tb/tb_dma_wr_arbiter.sv
// Self-checking bench for dma_wr_arbiter: an arbitration vector table plus hand-written
// burst sequences, with per-channel scoreboards checked on every accepted beat.
module tb_dma_wr_arbiter;
    import dma_pkg::*;

    localparam int DW = DmaDataW;
    localparam int AW = DmaAddrW;
    localparam int BW = DmaBcountW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          ch0_write = 1'b0, ch1_write = 1'b0;
    logic [AW-1:0] ch0_addr = '0, ch1_addr = '0;
    logic [BW-1:0] ch0_bcount = '0, ch1_bcount = '0;
    logic [DW-1:0] ch0_data = '0, ch1_data = '0;
    logic          ch0_wait_req_o, ch1_wait_req_o, ch0_burst_done_o, ch1_burst_done_o;
    logic          wr_master_write_o;
    logic [AW-1:0] wr_master_addr_o;
    logic [BW-1:0] wr_master_bcount_o;
    logic [DW-1:0] wr_master_data_o;
    logic          slave_wait = 1'b0;
    logic [1:0]    grant_o;

    always #5 clk = ~clk;

    dma_wr_arbiter #(.DATA_W(DW), .ADDR_W(AW), .BCOUNT_W(BW)) u_dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .ch0_write_i          (ch0_write),
        .ch0_addr_i           (ch0_addr),
        .ch0_bcount_i         (ch0_bcount),
        .ch0_data_i           (ch0_data),
        .ch0_wait_req_o       (ch0_wait_req_o),
        .ch0_burst_done_o     (ch0_burst_done_o),
        .ch1_write_i          (ch1_write),
        .ch1_addr_i           (ch1_addr),
        .ch1_bcount_i         (ch1_bcount),
        .ch1_data_i           (ch1_data),
        .ch1_wait_req_o       (ch1_wait_req_o),
        .ch1_burst_done_o     (ch1_burst_done_o),
        .wr_master_write_o    (wr_master_write_o),
        .wr_master_addr_o     (wr_master_addr_o),
        .wr_master_bcount_o   (wr_master_bcount_o),
        .wr_master_data_o     (wr_master_data_o),
        .wr_master_wait_req_i (slave_wait),
        .grant_o              (grant_o)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } beat_t;

    typedef struct {
        logic       r0;
        logic       r1;
        logic [1:0] exp_gnt;
    } vec_t;

    beat_t sb0[$];
    beat_t sb1[$];
    int n_cmp = 0, n_fail = 0;
    int acc_cnt = 0, done0_cnt = 0, done1_cnt = 0, cyc = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Beat monitor: a beat shown with write high and no wait is accepted at the next edge
    always @(negedge clk) begin : monitor
        beat_t e;
        if (reset_n) begin
            done0_cnt += int'(ch0_burst_done_o);
            done1_cnt += int'(ch1_burst_done_o);
            if (wr_master_write_o && !slave_wait) begin
                acc_cnt++;
                n_cmp++;
                if (grant_o == 2'b01 && sb0.size() > 0) begin
                    e = sb0.pop_front();
                end else if (grant_o == 2'b10 && sb1.size() > 0) begin
                    e = sb1.pop_front();
                end else begin
                    n_fail++;
                    $display("FAIL beat_unexpected: grant %b accepted a beat, expected none",
                             grant_o);
                    e.addr = wr_master_addr_o;
                    e.data = wr_master_data_o;
                end
                if (wr_master_addr_o !== e.addr || wr_master_data_o !== e.data) begin
                    n_fail++;
                    $display("FAIL beat_data: got addr %0h data %0h, expected addr %0h data %0h",
                             wr_master_addr_o, wr_master_data_o, e.addr, e.data);
                end
            end
        end
    end

    task automatic set_ch(input int ch, input logic w, input logic [AW-1:0] a,
                          input logic [BW-1:0] bc, input logic [DW-1:0] d);
        if (ch == 0) begin
            ch0_write = w; ch0_addr = a; ch0_bcount = bc; ch0_data = d;
        end else begin
            ch1_write = w; ch1_addr = a; ch1_bcount = bc; ch1_data = d;
        end
    endtask

    task automatic push_exp(input int ch, input logic [AW-1:0] a, input logic [DW-1:0] d);
        beat_t e;
        e.addr = a;
        e.data = d;
        if (ch == 0) sb0.push_back(e);
        else         sb1.push_back(e);
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Present nbeats beats on one channel, each held until accepted; optional bubble
    task automatic run_burst(input int ch, input logic [BW-1:0] bc, input int nbeats,
                             input logic [31:0] base, input int bubble_at,
                             input int bubble_len);
        bit            got;
        logic [DW-1:0] d;
        for (int b = 0; b < nbeats; b++) begin
            if (b == bubble_at) begin
                set_ch(ch, 1'b0, base, bc, '0);
                repeat (bubble_len) sync();
            end
            d = {8{base + 32'(b)}};
            set_ch(ch, 1'b1, base, bc, d);
            push_exp(ch, base, d);
            got = 1'b0;
            for (int k = 0; k < 100; k++) begin
                @(negedge clk);
                if (((ch == 0) ? ch0_wait_req_o : ch1_wait_req_o) == 1'b0) begin
                    got = 1'b1;
                    break;
                end
            end
            if (!got) begin
                n_cmp++;
                n_fail++;
                $display("FAIL beat_timeout: ch%0d beat %0d got no accept, expected accept",
                         ch, b);
                set_ch(ch, 1'b0, base, bc, '0);
                return;
            end
            sync();
        end
        set_ch(ch, 1'b0, base, bc, '0);
    endtask

    task automatic pulse_reset();
        sync();
        reset_n = 1'b0;
        sync();
        reset_n = 1'b1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vec_t vecs[7];
        int   d0, d1, a0, c0, bub;
        bit   got;

        // Arbitration table, starting from reset (ch0 favoured first)
        vecs[0] = '{1'b1, 1'b1, 2'b01};
        vecs[1] = '{1'b1, 1'b1, 2'b10};
        vecs[2] = '{1'b1, 1'b0, 2'b01};
        vecs[3] = '{1'b1, 1'b0, 2'b01};
        vecs[4] = '{1'b1, 1'b1, 2'b10};
        vecs[5] = '{1'b0, 1'b1, 2'b10};
        vecs[6] = '{1'b1, 1'b1, 2'b01};

        // Outputs under reset, even with a channel requesting
        set_ch(0, 1'b1, 32'hdead_beef, 11'd5, {8{32'h1234_5678}});
        #12;
        check("rst_grant", 64'(grant_o), 64'd0);
        check("rst_write", 64'(wr_master_write_o), 64'd0);
        check("rst_addr", 64'(wr_master_addr_o), 64'd0);
        check("rst_bcount", 64'(wr_master_bcount_o), 64'd0);
        check("rst_data_lo", wr_master_data_o[63:0], 64'd0);
        check("rst_wait", 64'({ch1_wait_req_o, ch0_wait_req_o}), 64'b11);
        check("rst_done", 64'({ch1_burst_done_o, ch0_burst_done_o}), 64'b00);
        set_ch(0, 1'b0, '0, '0, '0);
        sync();
        reset_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            sync();
            set_ch(0, vecs[i].r0, 32'(32'h100 + i), 11'd1, {8{32'(32'h100 + i)}});
            set_ch(1, vecs[i].r1, 32'(32'h200 + i), 11'd1, {8{32'(32'h200 + i)}});
            if (vecs[i].exp_gnt == 2'b01) push_exp(0, 32'(32'h100 + i), {8{32'(32'h100 + i)}});
            else                          push_exp(1, 32'(32'h200 + i), {8{32'(32'h200 + i)}});
            @(negedge clk);
            check("tbl_arb_latency", 64'(grant_o), 64'd0);
            check("tbl_idle_wait", 64'({ch1_wait_req_o, ch0_wait_req_o}), 64'b11);
            @(negedge clk);
            check("tbl_grant", 64'(grant_o), 64'(vecs[i].exp_gnt));
            check("tbl_done", 64'({ch1_burst_done_o, ch0_burst_done_o}), 64'(vecs[i].exp_gnt));
            sync();
            set_ch(0, 1'b0, '0, '0, '0);
            set_ch(1, 1'b0, '0, '0, '0);
            @(negedge clk);
            check("tbl_back_idle", 64'(grant_o), 64'd0);
        end

        // Simultaneous request after reset: ch0 first, ch1 after ch0's done and an idle gap
        pulse_reset();
        d0 = done0_cnt;
        d1 = done1_cnt;
        fork
            run_burst(0, 11'd2, 2, 32'ha000, -1, 0);
            run_burst(1, 11'd1, 1, 32'hb000, -1, 0);
            begin
                @(negedge clk);
                check("tie_arb_latency", 64'(grant_o), 64'd0);
                @(negedge clk);
                check("tie_ch0_first", 64'(grant_o), 64'b01);
                got = 1'b0;
                for (int k = 0; k < 50; k++) begin
                    if (ch0_burst_done_o) begin
                        got = 1'b1;
                        break;
                    end
                    @(negedge clk);
                end
                check("tie_ch0_done_seen", 64'(got), 64'd1);
                @(negedge clk);
                check("tie_idle_gap", 64'(grant_o), 64'd0);
                @(negedge clk);
                check("tie_ch1_second", 64'(grant_o), 64'b10);
            end
        join
        check("tie_done0_count", 64'(done0_cnt - d0), 64'd1);
        check("tie_done1_count", 64'(done1_cnt - d1), 64'd1);

        // ch1 burst of 4 with the slave stalling beat 2 for 3 cycles
        sync();
        d0 = done0_cnt;
        d1 = done1_cnt;
        a0 = acc_cnt;
        c0 = cyc;
        fork
            run_burst(1, 11'd4, 4, 32'hc100, -1, 0);
            begin
                for (int k = 0; k < 50; k++) begin
                    @(negedge clk);
                    if (!ch1_wait_req_o) break;
                end
                sync();
                slave_wait = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                slave_wait = 1'b0;
            end
        join
        check("stall_beats", 64'(acc_cnt - a0), 64'd4);
        check("stall_done1", 64'(done1_cnt - d1), 64'd1);
        check("stall_done0", 64'(done0_cnt - d0), 64'd0);
        check("stall_cycles", 64'(cyc - c0), 64'd8);

        // ch0 bcount=0 behaves as a single-beat burst
        sync();
        d0 = done0_cnt;
        run_burst(0, 11'd0, 1, 32'hd200, -1, 0);
        @(negedge clk);
        check("bc0_idle", 64'(grant_o), 64'd0);
        check("bc0_wait", 64'(ch0_wait_req_o), 64'd1);
        check("bc0_done", 64'(done0_cnt - d0), 64'd1);

        // Bubble in a ch0 burst while ch1 requests: ch0 keeps the master
        sync();
        bub = 0;
        fork
            run_burst(0, 11'd3, 3, 32'he300, 1, 2);
            begin
                sync();
                run_burst(1, 11'd1, 1, 32'hf300, -1, 0);
            end
            begin
                @(posedge clk);
                got = 1'b0;
                for (int k = 0; k < 50; k++) begin
                    @(negedge clk);
                    check("hold_grant", 64'(grant_o), 64'b01);
                    check("hold_ch1_wait", 64'(ch1_wait_req_o), 64'd1);
                    if (!wr_master_write_o) bub++;
                    if (ch0_burst_done_o) begin
                        got = 1'b1;
                        break;
                    end
                end
                check("hold_done_seen", 64'(got), 64'd1);
                check("hold_bubble_cycles", 64'(bub), 64'd2);
            end
        join

        // Asynchronous reset during beat 2 of an 8-beat ch1 burst
        sync();
        set_ch(1, 1'b1, 32'h0000_c800, 11'd8, {8{32'h0000_c800}});
        push_exp(1, 32'h0000_c800, {8{32'h0000_c800}});
        got = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (!ch1_wait_req_o) begin
                got = 1'b1;
                break;
            end
        end
        check("arst_first_beat", 64'(got), 64'd1);
        sync();
        set_ch(1, 1'b1, 32'h0000_c800, 11'd8, {8{32'h0000_c801}});
        d0 = done0_cnt;
        d1 = done1_cnt;
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_grant", 64'(grant_o), 64'd0);
        check("arst_write", 64'(wr_master_write_o), 64'd0);
        check("arst_wait", 64'({ch1_wait_req_o, ch0_wait_req_o}), 64'b11);
        check("arst_done", 64'({ch1_burst_done_o, ch0_burst_done_o}), 64'b00);
        set_ch(1, 1'b0, '0, '0, '0);
        sync();
        sync();
        reset_n = 1'b1;
        check("arst_no_done", 64'((done0_cnt - d0) + (done1_cnt - d1)), 64'd0);
        set_ch(0, 1'b1, 32'h0000_d900, 11'd1, {8{32'h0000_d900}});
        set_ch(1, 1'b1, 32'h0000_e900, 11'd1, {8{32'h0000_e900}});
        push_exp(0, 32'h0000_d900, {8{32'h0000_d900}});
        @(negedge clk);
        check("arst_arb_latency", 64'(grant_o), 64'd0);
        @(negedge clk);
        check("arst_ch0_wins", 64'(grant_o), 64'b01);
        sync();
        set_ch(0, 1'b0, '0, '0, '0);
        set_ch(1, 1'b0, '0, '0, '0);
        @(negedge clk);
        check("arst_back_idle", 64'(grant_o), 64'd0);

        check("sb0_drained", 64'(sb0.size()), 64'd0);
        check("sb1_drained", 64'(sb1.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dma_wr_arbiter.md
DMA_WR_ARBITER -- requirements
Module: dma_wr_arbiter

Interface
REQ-001 The module SHALL have parameter DATA_W, default 256, meaning the write data width in bits.
REQ-002 The module SHALL have parameter ADDR_W, default 32, meaning the byte address width.
REQ-003 The module SHALL have parameter BCOUNT_W, default 11, meaning the burst count width.
REQ-004 The module SHALL have port clk, input, 1, the single clock; all logic SHALL be on its rising edge.
REQ-005 The module SHALL have port reset_n, input, 1, the reset: asynchronous and active-low.
REQ-006 For N in {0,1}, the module SHALL have chN_write_i, input, 1: channel N presents a write beat.
REQ-007 For N in {0,1}, the module SHALL have chN_addr_i, input, ADDR_W: channel N burst address.
REQ-008 For N in {0,1}, the module SHALL have chN_bcount_i, input, BCOUNT_W: channel N burst beat count.
REQ-009 For N in {0,1}, the module SHALL have chN_data_i, input, DATA_W: channel N write data.
REQ-010 For N in {0,1}, the module SHALL have chN_wait_req_o, output, 1: stall to channel N.
REQ-011 For N in {0,1}, the module SHALL have chN_burst_done_o, output, 1: one-cycle pulse when channel N's last beat is accepted.
REQ-012 The module SHALL have wr_master_write_o, wr_master_addr_o (ADDR_W), wr_master_bcount_o (BCOUNT_W) and wr_master_data_o (DATA_W), all outputs: the shared AVMM burst write master.
REQ-013 The module SHALL have wr_master_wait_req_i, input, 1: the AVMM waitrequest.
REQ-014 The module SHALL have grant_o, output, 2: one-hot current owner; 2'b00 when idle.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, GRANT0 and GRANT1.
REQ-016 In IDLE, both chN_wait_req_o SHALL be 1, and all wr_master_* outputs SHALL be 0.
REQ-017 In IDLE, with exactly one chN_write_i high, the next state SHALL be GRANTN; arbitration latency is exactly one cycle.
REQ-018 In IDLE, with both requests high, the channel not recorded in last_grant SHALL win.
REQ-019 last_grant SHALL update to the winner on each IDLE-to-GRANT transition.
REQ-020 In GRANTN, wr_master_write_o, addr, bcount and data SHALL be combinationally muxed from channel N with zero added latency.
REQ-021 In GRANTN, chN_wait_req_o SHALL equal wr_master_wait_req_i, and the other channel's wait_req SHALL be 1.
REQ-022 A beat SHALL be accepted when wr_master_write_o=1 and wr_master_wait_req_i=0.
REQ-023 On the first accepted beat of a burst, beats_left SHALL load chN_bcount_i - 1; a bcount of 0 SHALL be treated as 1.
REQ-024 On each subsequent accepted beat, beats_left SHALL decrement by 1.
REQ-025 Address and bcount SHALL be significant only on the first beat, per AVMM semantics.
REQ-026 If chN_write_i deasserts mid-burst (a bubble), the grant SHALL be held; there is no timeout.
REQ-027 When the last beat is accepted (first beat with bcount<=1, or beats_left==1), the arbiter SHALL pulse chN_burst_done_o and return to IDLE the next cycle.
REQ-028 Back-to-back bursts from the same channel SHALL therefore have a one-cycle IDLE gap.
REQ-029 The arbiter SHALL NOT preempt mid-burst; the other channel waits even if it is requesting.

Reset
REQ-030 reset_n low SHALL asynchronously force state to IDLE, beats_left to 0, last_grant to 1 (channel 0 wins first) and a first_beat flag to 1.
REQ-031 Under reset_n low, grant_o=0, wr_master_write_o=0, chN_wait_req_o=1 and chN_burst_done_o=0.
REQ-032 Reset asserted mid-burst SHALL abandon the burst; no done pulse SHALL be issued.

Structure
REQ-033 The state encoding and the DATA_W/ADDR_W/BCOUNT_W defaults SHALL live in the shared package dma_pkg.
REQ-034 The module SHALL be flat apart from one optional sub-module, dma_rr_pick2 (the two-way round-robin pick).

Verification
REQ-035 The bench SHALL cover: after reset, ch0 and ch1 request together in the same cycle -> ch0 granted the following cycle; ch1 granted after ch0's done pulse.
REQ-036 The bench SHALL cover: ch1 bcount=4 with wait_req high on beat 2 for 3 cycles -> exactly 4 accepted beats, then ch1_burst_done_o pulses once.
REQ-037 The bench SHALL cover: ch0 bcount=0 -> 1 beat, then done pulse, then IDLE.
REQ-038 The bench SHALL cover: ch0 bcount=3 with ch0_write_i low for 2 cycles mid-burst and ch1 requesting -> ch0 keeps the grant, and ch1_wait_req_o stays 1 until ch0 is done.
REQ-039 The bench SHALL cover: reset_n pulsed low asynchronously during ch1 beat 2 of 8 -> outputs reach reset values immediately, no done pulse, and ch0 wins the next contest.
